// File: rtl/data_register_pkg.sv
// Shared limits for the data register width parameter.
package data_register_pkg;
    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 1024;
endpackage

// File: rtl/data_register.sv
// Single-word storage register with write enable and asynchronous active-high reset.
// dout comes straight from the flops, so there is no combinational path from din or we.
module data_register
    import data_register_pkg::*;
#(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,   // active-high despite the name
    input  logic             we,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("data_register: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
        end
    endgenerate

    logic [WIDTH-1:0] r_word;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn)
            r_word <= RST_VAL;
        else if (we)
            r_word <= din;
    end

    assign dout = r_word;

endmodule

// File: tb/tb_data_register.sv
// Directed bench for data_register: a 512-bit default instance and an 8-bit instance with a non-zero reset value.
module tb_data_register;
    logic         clk;
    logic         rst0, we0;
    logic [511:0] din0, dout0;
    logic         rst1, we1;
    logic [7:0]   din1, dout1;

    int n_tests = 0;
    int n_fail  = 0;

    data_register #(512) u_wide (
        .clk(clk), .rstn(rst0), .we(we0), .din(din0), .dout(dout0)
    );

    data_register #(8, 8'hA5) u_byte (
        .clk(clk), .rstn(rst1), .we(we1), .din(din1), .dout(dout1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // Drive on the falling edge, then sample 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [511:0] pat, last, a, b, c;

    initial begin
        rst0 = 1'b1; we0 = 1'b0; din0 = '0;
        rst1 = 1'b1; we1 = 1'b0; din1 = '0;
        for (int i = 0; i < 16; i++) pat[32*i +: 32] = 32'(i);
        a = {16{32'hAAAA_0001}};
        b = {16{32'h5555_0002}};
        c = {16{32'h1234_5678}};

        #1;
        chk("rst_no_edge", dout0, '0);
        chk("rst_val_8", {504'd0, dout1}, {504'd0, 8'hA5});

        // write attempted during reset is discarded
        @(negedge clk); we0 = 1'b1; din0 = '1;
        step();
        chk("rst_beats_we", dout0, '0);

        @(negedge clk); rst0 = 1'b0; we0 = 1'b0;
        step();
        chk("after_release", dout0, '0);

        @(negedge clk); we0 = 1'b1; din0 = pat;
        step();
        chk("pattern", dout0, pat);
        chk("pattern_top", {480'd0, dout0[511:480]}, {480'd0, 32'hF});

        last = pat;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            we0 = 1'b0;
            for (int j = 0; j < 16; j++) din0[32*j +: 32] = $urandom;
            step();
            chk($sformatf("hold_%0d", k), dout0, last);
        end

        @(negedge clk); we0 = 1'b0; din0 = 'x;
        step();
        chk("hold_x_din", dout0, last);

        @(negedge clk); we0 = 1'b1; din0 = a;
        step();
        chk("b2b_A", dout0, a);
        @(negedge clk); din0 = b;
        step();
        chk("b2b_B", dout0, b);
        @(negedge clk); din0 = c;
        step();
        chk("b2b_C", dout0, c);

        // reset between edges clears immediately; pending writes lost
        @(negedge clk); din0 = a;
        step();
        chk("pre_rst_A", dout0, a);
        @(negedge clk); din0 = b; rst0 = 1'b1;
        #1;
        chk("async_rst", dout0, '0);
        step();
        chk("rst_hold_we1", dout0, '0);
        @(negedge clk); rst0 = 1'b0; din0 = c;
        step();
        chk("first_after_rst", dout0, c);

        @(negedge clk); rst1 = 1'b0; we1 = 1'b0; din1 = 8'hFF;
        step();
        chk("byte_no_we", {504'd0, dout1}, {504'd0, 8'hA5});
        @(negedge clk); we1 = 1'b1; din1 = 8'h3C;
        step();
        chk("byte_write", {504'd0, dout1}, {504'd0, 8'h3C});
        @(negedge clk); we1 = 1'b0; rst1 = 1'b1;
        #1;
        chk("byte_rst", {504'd0, dout1}, {504'd0, 8'hA5});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/data_register.md
DATA_REGISTER -- requirements
Module: data_register

Interface
REQ-001 Parameter WIDTH, default 32: data width in bits; legal range 1..1024; the write-buffer instance uses 512.
REQ-002 Parameter RST_VAL, default all-zeros (WIDTH bits): value loaded into the stored word on reset.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rstn  input  1: reset, asynchronous, active-high (asserted = 1); the port keeps the codebase name rstn.
REQ-005 Port we  input  1: write enable; sampled at the rising edge of clk.
REQ-006 Port din  input  WIDTH: write data.
REQ-007 Port dout  output  WIDTH: stored word, driven directly from the storage flops.

Function
REQ-008 The block SHALL hold one WIDTH-bit word in flops.
REQ-009 The block SHALL load din into the word at a rising clk edge when we=1 and reset is deasserted.
REQ-010 The block SHALL keep the word unchanged at a rising clk edge when we=0.
REQ-011 Write latency SHALL be one cycle: the new value appears on dout immediately after the capturing edge and stays there until the next write or reset.
REQ-012 dout SHALL have no combinational path from din or we; it is a pure flop output.
REQ-013 All WIDTH bits SHALL be written together; there is no partial or byte-lane write.
REQ-014 The block SHALL impose no handshake; we may be held at 1 on consecutive cycles and each edge captures the current din.
REQ-015 X or Z on din with we=0 SHALL NOT affect dout.
REQ-016 The block SHALL contain no state machine; its only state is the stored word.

Reset
REQ-017 While rstn=1, dout SHALL equal RST_VAL, with or without a clock edge.
REQ-018 Reset SHALL take precedence over we: a write on the same edge as active reset is discarded.
REQ-019 After rstn deasserts, the first rising edge with we=1 SHALL capture din.
REQ-020 Reset asserted in the middle of a sequence of writes SHALL clear the word immediately; writes pending on later edges are lost until reset releases.

Structure
REQ-021 The block SHALL be one leaf module with no sub-modules.
REQ-022 WIDTH and RST_VAL SHALL be module parameters; no shared package entries are required.
REQ-023 An elaboration-time check SHALL reject WIDTH < 1 or WIDTH > 1024.
REQ-024 The module SHALL be instantiable by named ports clk, rstn, we, din, dout with a positional WIDTH override.

Verification
REQ-025 WIDTH=512: assert reset, then release it -> dout=0 both during and after reset.
REQ-026 WIDTH=512: we=1 with din = 16 words 32'h0..32'hF (word i in bits [32i+31:32i]) -> dout equals that pattern one edge later; bits [511:480]=32'hF.
REQ-027 we=0 for 20 cycles with random din -> dout holds its last written value.
REQ-028 Back-to-back writes A, B, C on consecutive edges -> dout shows A, B, C on consecutive cycles.
REQ-029 Assert reset between clock edges while dout=A -> dout goes to RST_VAL without a clock edge; we=1 during reset -> no capture.
REQ-030 WIDTH=8 with RST_VAL=8'hA5: reset -> dout=8'hA5; write 8'h3C -> dout=8'h3C.
